// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the Wishbone UART.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_RX_OVR    = 5;
  localparam int ST_FRAME_ERR = 6;
  localparam int ST_TX_OVF    = 7;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_LOOP  = 2;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/wb_uart_slave_if.sv
// Wishbone classic bus bundle between the MEM-stage master and the UART.
interface wb_uart_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i,
    output wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i,
    input  wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign o_count = r_wp - r_rp;
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_dout  = r_mem[r_rp[AW-1:0]];

  // a pop frees a slot, so a push into a full FIFO still lands
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/wb_uart_slave.sv
// Wishbone classic 8N1 UART: register block plus TX and RX bit engines.
module wb_uart_slave #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic              clk,
  input  logic              rst,
  wb_uart_slave_if.slave    wb,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              irq
);
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        r_ack, r_irq;
  logic [31:0] r_dat_o;
  logic [15:0] r_div;
  logic [2:0]  r_ctrl;
  logic        r_rx_ovr, r_ferr, r_tx_ovf;
  logic        w_req, w_wr, w_rd, w_clr;
  logic [1:0]  w_off;
  logic [31:0] w_rdata;
  logic [7:0]  w_stat;

  logic          w_txf_push, w_txf_full, w_txf_empty;
  logic [7:0]    w_txf_head;
  logic [CW-1:0] w_txf_cnt;
  logic          w_rxf_push, w_rxf_pop, w_rxf_full, w_rxf_empty;
  logic [7:0]    w_rxf_head;
  logic [CW-1:0] w_rxf_cnt;

  uart_state_e r_tx_st, w_tx_st_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
  logic [2:0]  r_tx_bit, w_tx_bit_n;
  logic [7:0]  r_tx_sh, w_tx_sh_n;
  logic        w_tx_pop, w_tx_end, w_tx_busy, w_tx_line;

  uart_state_e r_rx_st, w_rx_st_n;
  logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n;
  logic [2:0]  r_rx_bit, w_rx_bit_n;
  logic [7:0]  r_rx_sh, w_rx_sh_n;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        w_rx_src, w_rx_fall, w_rx_end, w_rx_mid, w_rx_ferr;
  logic        w_unused_bits;

  assign w_req = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr  = w_req & wb.wb_we_i;
  assign w_rd  = w_req & ~wb.wb_we_i;
  assign w_off = wb.wb_adr_i[3:2];
  assign w_clr = w_wr && (w_off == REG_STATUS);

  assign w_txf_push = w_wr && (w_off == REG_DATA);
  assign w_rxf_pop  = w_rd && (w_off == REG_DATA);

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat_o;
  assign irq         = r_irq;
  assign uart_tx     = w_tx_line;
  assign w_tx_busy   = (r_tx_st != S_IDLE);

  assign w_stat = {r_tx_ovf, r_ferr, r_rx_ovr, w_tx_busy,
                   w_txf_full, w_txf_empty, w_rxf_full, ~w_rxf_empty};

  assign w_unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                           wb.wb_dat_i[31:16], w_txf_cnt, w_rxf_cnt};

  always_comb begin
    w_rdata = '0;
    case (w_off)
      REG_DATA:   w_rdata = w_rxf_empty ? '0 : {24'b0, w_rxf_head};
      REG_STATUS: w_rdata = {24'b0, w_stat};
      REG_BAUD:   w_rdata = {16'b0, r_div};
      default:    w_rdata = {29'b0, r_ctrl};
    endcase
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst(rst),
    .i_push(w_txf_push), .i_din(wb.wb_dat_i[7:0]),
    .i_pop(w_tx_pop), .o_dout(w_txf_head),
    .o_full(w_txf_full), .o_empty(w_txf_empty), .o_count(w_txf_cnt)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst(rst),
    .i_push(w_rxf_push), .i_din(r_rx_sh),
    .i_pop(w_rxf_pop), .o_dout(w_rxf_head),
    .o_full(w_rxf_full), .o_empty(w_rxf_empty), .o_count(w_rxf_cnt)
  );

  // sticky flags: a same-cycle set beats a write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_dat_o  <= '0;
      r_div    <= DIV_RESET;
      r_ctrl   <= '0;
      r_rx_ovr <= 1'b0;
      r_ferr   <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_dat_o <= w_rd ? w_rdata : '0;
      if (w_wr && (w_off == REG_BAUD))
        r_div <= clamp_div(wb.wb_dat_i[15:0]);
      if (w_wr && (w_off == REG_CTRL))
        r_ctrl <= wb.wb_dat_i[2:0];
      r_tx_ovf <= (w_txf_push & w_txf_full & ~w_tx_pop) |
                  (r_tx_ovf & ~(w_clr & wb.wb_dat_i[ST_TX_OVF]));
      r_rx_ovr <= (w_rxf_push & w_rxf_full & ~w_rxf_pop) |
                  (r_rx_ovr & ~(w_clr & wb.wb_dat_i[ST_RX_OVR]));
      r_ferr   <= w_rx_ferr |
                  (r_ferr & ~(w_clr & wb.wb_dat_i[ST_FRAME_ERR]));
      r_irq    <= (r_ctrl[CTRL_RX_IE] & ~w_rxf_empty) |
                  (r_ctrl[CTRL_TX_IE] & w_txf_empty & ~w_tx_busy);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_div <= DIV_RESET;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
    end else begin
      r_tx_st  <= w_tx_st_n;
      r_tx_cnt <= w_tx_cnt_n;
      r_tx_div <= w_tx_div_n;
      r_tx_bit <= w_tx_bit_n;
      r_tx_sh  <= w_tx_sh_n;
    end
  end

  assign w_tx_end = (r_tx_cnt == r_tx_div - 16'd1);

  always_comb begin
    w_tx_st_n  = r_tx_st;
    w_tx_cnt_n = r_tx_cnt + 16'd1;
    w_tx_div_n = r_tx_div;
    w_tx_bit_n = r_tx_bit;
    w_tx_sh_n  = r_tx_sh;
    w_tx_pop   = 1'b0;
    w_tx_line  = 1'b1;
    unique case (r_tx_st)
      S_IDLE: begin
        w_tx_cnt_n = '0;
        if (!w_txf_empty) begin
          w_tx_pop   = 1'b1;
          w_tx_sh_n  = w_txf_head;
          w_tx_div_n = r_div;
          w_tx_st_n  = S_START;
        end
      end
      S_START: begin
        w_tx_line = 1'b0;
        if (w_tx_end) begin
          w_tx_cnt_n = '0;
          w_tx_bit_n = '0;
          w_tx_st_n  = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_line = r_tx_sh[0];
        if (w_tx_end) begin
          w_tx_cnt_n = '0;
          w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
          w_tx_bit_n = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_st_n = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tx_end) begin
          w_tx_cnt_n = '0;
          w_tx_st_n  = S_IDLE;
          // chain the next frame with no idle gap
          if (!w_txf_empty) begin
            w_tx_pop   = 1'b1;
            w_tx_sh_n  = w_txf_head;
            w_tx_div_n = r_div;
            w_tx_st_n  = S_START;
          end
        end
      end
      default: w_tx_st_n = S_IDLE;
    endcase
  end

  assign w_rx_src  = r_ctrl[CTRL_LOOP] ? w_tx_line : uart_rx;
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_end  = (r_rx_cnt == r_rx_div - 16'd1);
  assign w_rx_mid  = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= S_IDLE;
      r_rx_cnt  <= '0;
      r_rx_div  <= DIV_RESET;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
    end else begin
      r_rx_s1   <= w_rx_src;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_st   <= w_rx_st_n;
      r_rx_cnt  <= w_rx_cnt_n;
      r_rx_div  <= w_rx_div_n;
      r_rx_bit  <= w_rx_bit_n;
      r_rx_sh   <= w_rx_sh_n;
    end
  end

  always_comb begin
    w_rx_st_n  = r_rx_st;
    w_rx_cnt_n = r_rx_cnt + 16'd1;
    w_rx_div_n = r_rx_div;
    w_rx_bit_n = r_rx_bit;
    w_rx_sh_n  = r_rx_sh;
    w_rxf_push = 1'b0;
    w_rx_ferr  = 1'b0;
    unique case (r_rx_st)
      S_IDLE: begin
        w_rx_cnt_n = '0;
        if (w_rx_fall) begin
          w_rx_div_n = r_div;
          w_rx_st_n  = S_START;
        end
      end
      S_START: begin
        if (w_rx_mid) begin
          w_rx_cnt_n = '0;
          w_rx_bit_n = '0;
          w_rx_st_n  = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt_n = '0;
          w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_bit_n = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_st_n = S_STOP;
        end
      end
      S_STOP: begin
        if (w_rx_end) begin
          w_rxf_push = r_rx_s2;
          w_rx_ferr  = ~r_rx_s2;
          w_rx_st_n  = S_IDLE;
        end
      end
      default: w_rx_st_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_uart_slave.sv
// Scoreboard bench: bus reads and serial TX frames are checked against queues.
module tb_wb_uart_slave;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic uart_tx;
  logic irq;

  wb_uart_slave_if bus();

  wb_uart_slave #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .clk(clk), .rst(rst), .wb(bus),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } rd_t;

  rd_t        rd_q[$];
  logic [7:0] tx_exp_q[$];
  int checks = 0;
  int errors = 0;
  int tb_div = 434;
  int frames = 0;
  bit mon_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // read-data monitor
  always @(negedge clk) begin
    if (bus.wb_ack_o && !bus.wb_we_i) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h expected none", bus.wb_dat_o);
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        chk(e.nm, bus.wb_dat_o, e.exp);
      end
    end
  end

  // serial TX frame monitor
  initial begin : txmon
    logic prev;
    logic [7:0] b;
    logic stp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && uart_tx === 1'b0) begin
        repeat (tb_div + tb_div / 2) @(negedge clk);
        b[0] = uart_tx;
        for (int k = 1; k < 8; k++) begin
          repeat (tb_div) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (tb_div) @(negedge clk);
        stp = uart_tx;
        if (mon_en) begin
          frames++;
          chk("tx_stop", {31'b0, stp}, 32'd1);
          if (tx_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %h expected none", b);
          end else begin
            chk("tx_byte", {24'b0, b}, {24'b0, tx_exp_q.pop_front()});
          end
        end
      end
      prev = uart_tx;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic we, input logic [1:0] off,
                        input logic [31:0] d, input string nm,
                        input logic [31:0] exp);
    bit got;
    got = 1'b0;
    if (!we) rd_q.push_back('{exp, nm});
    bus.wb_adr_i = {28'h0007F20, off, 2'b00};
    bus.wb_dat_i = d;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout %s: got no ack expected ack", nm);
      if (!we) void'(rd_q.pop_back());
    end
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    bus_op(1'b1, off, d, "wr", 32'h0);
  endtask

  task automatic rd(input logic [1:0] off, input string nm,
                    input logic [31:0] exp);
    bus_op(1'b0, off, 32'h0, nm, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stp);
    uart_rx = 1'b0;
    cyc(tb_div);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      cyc(tb_div);
    end
    uart_rx = stp;
    cyc(tb_div);
    uart_rx = 1'b1;
  endtask

  initial begin
    logic [7:0]  v55;
    logic        exp_bit;
    int          bad;
    rst = 1'b1;
    uart_rx = 1'b1;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
    rd(2'd1, "rst_status", 32'h04);
    rd(2'd2, "rst_baud", 32'd434);
    rd(2'd3, "rst_ctrl", 32'h0);
    rd(2'd0, "rst_data_empty", 32'h0);

    // divisor clamp and 0x55 waveform
    wr(2'd2, 32'd2);
    rd(2'd2, "baud_clamp", 32'd4);
    tb_div = 4;
    v55 = 8'h55;
    tx_exp_q.push_back(v55);
    wr(2'd0, 32'h55);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4) exp_bit = 1'b0;
      else if (i < 36) exp_bit = v55[(i - 4) / 4];
      else exp_bit = 1'b1;
      if (uart_tx !== exp_bit) bad++;
    end
    chk("tx_wave_55_bad_samples", bad, 0);
    @(posedge clk);
    #1;
    frames = 0;

    // TX overflow behind a busy frame
    tx_exp_q.push_back(8'h10);
    wr(2'd0, 32'h10);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp_q.push_back(8'h20 + 8'(i));
      wr(2'd0, 32'h20 + i);
    end
    rd(2'd1, "ovf_status", 32'h98);
    wr(2'd1, 32'h80);
    rd(2'd1, "ovf_cleared", 32'h18);
    cyc(420);
    chk("tx_frame_count", frames, 9);
    rd(2'd1, "tx_drained", 32'h04);

    // loopback
    wr(2'd3, 32'h4);
    wr(2'd2, 32'd8);
    tb_div = 8;
    tx_exp_q.push_back(8'hA3);
    tx_exp_q.push_back(8'h0F);
    wr(2'd0, 32'hA3);
    wr(2'd0, 32'h0F);
    cyc(200);
    rd(2'd1, "lb_status", 32'h05);
    rd(2'd0, "lb_byte0", 32'hA3);
    rd(2'd0, "lb_byte1", 32'h0F);
    rd(2'd0, "lb_empty", 32'h00);
    rd(2'd1, "lb_status_empty", 32'h04);
    wr(2'd3, 32'h0);

    // frame error, then glitch, then a good frame
    send_rx(8'h3C, 1'b0);
    cyc(10);
    rd(2'd1, "ferr_status", 32'h44);
    rd(2'd0, "ferr_no_data", 32'h00);
    wr(2'd1, 32'h40);
    rd(2'd1, "ferr_cleared", 32'h04);
    uart_rx = 1'b0;
    cyc(2);
    uart_rx = 1'b1;
    cyc(40);
    rd(2'd1, "glitch_status", 32'h04);
    send_rx(8'h5A, 1'b1);
    cyc(10);
    rd(2'd0, "after_glitch", 32'h5A);

    // RX interrupt and overrun
    wr(2'd3, 32'h1);
    cyc(2);
    chk("irq_idle", {31'b0, irq}, 32'd0);
    send_rx(8'h81, 1'b1);
    cyc(4);
    chk("irq_rx", {31'b0, irq}, 32'd1);
    for (int i = 1; i < 8; i++) send_rx(8'h81 + 8'(i), 1'b1);
    cyc(4);
    rd(2'd1, "rx_full_status", 32'h07);
    send_rx(8'h89, 1'b1);
    cyc(4);
    rd(2'd1, "rx_ovr_status", 32'h27);
    for (int i = 0; i < 8; i++) rd(2'd0, "rx_fifo_byte", 32'h81 + i);
    cyc(2);
    chk("irq_drained", {31'b0, irq}, 32'd0);
    rd(2'd1, "rx_ovr_sticky", 32'h24);
    wr(2'd1, 32'h20);
    rd(2'd1, "rx_ovr_cleared", 32'h04);
    wr(2'd3, 32'h2);
    cyc(2);
    chk("irq_tx_empty", {31'b0, irq}, 32'd1);
    wr(2'd3, 32'h0);

    // reset in mid-frame
    mon_en = 1'b0;
    wr(2'd0, 32'h00);
    cyc(10);
    chk("tx_midframe", {31'b0, uart_tx}, 32'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("tx_after_rst", {31'b0, uart_tx}, 32'd1);
    rd(2'd1, "rst2_status", 32'h04);
    rd(2'd2, "rst2_baud", 32'd434);
    cyc(4);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
